// File: rtl/token_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : token_sched_pkg
// Description : Shared state encoding and default parameter values for the
//               token scheduler and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package token_sched_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int CNT_W_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    // IDLE: unconfigured, RUN: dividing tokens, PEND: new ratio waiting for wrap
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } sched_state_t;

endpackage : token_sched_pkg
`default_nettype wire

// File: rtl/token_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Searches the request
//               vector starting one past the last granted index and returns
//               a one-hot grant plus an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import token_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Walk the requesters in rotating order and take the first one asserted
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(i_last_grant) + i) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/token_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : token_scheduler
// Description : Divides a serial token stream by a configurable ratio and
//               hands each selected token to one requester in round-robin
//               order. Unserved selections pulse drop and bump a saturating
//               counter. Ratio changes mid-period are deferred until the
//               token counter returns to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module token_scheduler
    import token_sched_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic [N_REQ-1:0]  req,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [N_REQ-1:0]  grant,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_pend;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_div_nxt;
    logic [CNT_W-1:0]  w_pend_nxt;
    logic [CNT_W-1:0]  w_div_eff;
    logic [CNT_W-1:0]  w_cfg_div;
    logic              w_cfg_ready;
    logic              w_hs;
    logic              w_tok_en;
    logic              w_sel;
    logic [N_REQ-1:0]  w_arb_grant;
    logic              w_arb_any;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [IDX_W-1:0]  r_last_grant;
    logic [N_REQ-1:0]  r_grant;
    logic              r_drop;
    logic [DROP_W-1:0] r_drop_cnt;

    // A zero ratio would never select; treat it as "every token"
    assign w_cfg_div   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    assign w_cfg_ready = (r_state != PEND);
    assign w_hs        = cfg_valid & w_cfg_ready;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any        (w_arb_any)
    );

    // Next-state, ratio bookkeeping and token selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_pend_nxt  = r_pend;
        w_div_eff   = r_div;
        w_tok_en    = 1'b0;
        w_sel       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_div_nxt   = w_cfg_div;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_tok_en = 1'b1;
                if (w_hs) begin
                    // Only a quiet cycle at count zero can swap ratio at once
                    if (r_cnt == '0 && !a) begin
                        w_div_nxt = w_cfg_div;
                    end else begin
                        w_pend_nxt  = w_cfg_div;
                        w_state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                w_tok_en = 1'b1;
                // Counter back at zero: new ratio governs this cycle's token
                if (r_cnt == '0) begin
                    w_div_eff   = r_pend;
                    w_div_nxt   = r_pend;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_tok_en && a) begin
            if (r_cnt == w_div_eff - CNT_W'(1)) begin
                w_sel     = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Convert the arbiter's one-hot pick into an index for rotation
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_grant[i]) begin
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, ratio registers and registered grant/drop outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_div        <= CNT_W'(1);
            r_pend       <= CNT_W'(1);
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_grant      <= '0;
            r_drop       <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_pend  <= w_pend_nxt;
            r_grant <= (w_sel && w_arb_any) ? w_arb_grant : '0;
            r_drop  <= w_sel && !w_arb_any;
            if (w_sel && w_arb_any) begin
                r_last_grant <= w_grant_idx;
            end
            if (w_sel && !w_arb_any && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign grant     = r_grant;
    assign drop      = r_drop;
    assign drop_cnt  = r_drop_cnt;

endmodule : token_scheduler
`default_nettype wire

// File: tb/tb_token_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_token_scheduler
// Description : Self-checking bench for token_scheduler. A behavioural model
//               tracks tokens, ratio and round-robin pointer; every cycle the
//               DUT outputs are compared against it. Directed scenarios also
//               pin literal expectations. A second instance with a 2-bit drop
//               counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_token_scheduler;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic [3:0] req;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic [3:0] grant;
    logic       drop;
    logic [7:0] drop_cnt;
    logic       cfg_ready2;
    logic [3:0] grant2;
    logic       drop2;
    logic [1:0] drop_cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    token_scheduler #(.N_REQ(4), .CNT_W(4), .DROP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .req(req),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .grant(grant), .drop(drop), .drop_cnt(drop_cnt)
    );

    token_scheduler #(.N_REQ(4), .CNT_W(4), .DROP_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .req(req),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready2),
        .grant(grant2), .drop(drop2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 = idle, 1 = running, 2 = ratio change pending
    int         m_st, m_cnt, m_div, m_pend, m_last, m_dc1, m_dc2;
    logic [3:0] m_grant;
    logic       m_drop;
    int         s_st0, s_cnt0, s_nd, s_idx;
    bit         s_hs, s_sel, s_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_div = 1; m_pend = 1; m_last = 3;
            m_dc1 = 0; m_dc2 = 0; m_grant = 4'd0; m_drop = 1'b0;
        end else begin
            s_st0   = m_st;
            s_cnt0  = m_cnt;
            m_grant = 4'd0;
            m_drop  = 1'b0;
            s_sel   = 1'b0;
            s_hs    = cfg_valid && (m_st != 2);
            s_nd    = (cfg_div == 4'd0) ? 1 : int'(cfg_div);
            if (s_st0 == 0) begin
                if (s_hs) begin
                    m_div = s_nd; m_cnt = 0; m_st = 1;
                end
            end else begin
                if (s_st0 == 2 && s_cnt0 == 0) begin
                    m_div = m_pend; m_st = 1;
                end
                if (a) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == m_div) begin
                        m_cnt = 0; s_sel = 1'b1;
                    end
                end
                if (s_sel) begin
                    if (req == 4'd0) begin
                        m_drop = 1'b1;
                        if (m_dc1 < 255) m_dc1 = m_dc1 + 1;
                        if (m_dc2 < 3)   m_dc2 = m_dc2 + 1;
                    end else begin
                        s_found = 1'b0;
                        for (int k = 1; k <= 4; k++) begin
                            s_idx = (m_last + k) % 4;
                            if (!s_found && req[s_idx]) begin
                                s_found = 1'b1;
                                m_grant[s_idx] = 1'b1;
                                m_last = s_idx;
                            end
                        end
                    end
                end
                if (s_st0 == 1 && s_hs) begin
                    if (s_cnt0 == 0 && !a) m_div = s_nd;
                    else begin
                        m_pend = s_nd; m_st = 2;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",     {28'd0, grant},     {28'd0, m_grant});
            chk("drop",      {31'd0, drop},      {31'd0, m_drop});
            chk("drop_cnt",  {24'd0, drop_cnt},  m_dc1);
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, (m_st != 2)});
            chk("grant2",    {28'd0, grant2},    {28'd0, m_grant});
            chk("drop_cnt2", {30'd0, drop_cnt2}, m_dc2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit ta, input logic [3:0] treq, input bit tv, input logic [3:0] td);
        a = ta; req = treq; cfg_valid = tv; cfg_div = td;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        a = 1'b0; req = 4'd0; cfg_valid = 1'b0; cfg_div = 4'd0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] tab[8];
    int         n_drop;
    logic [3:0] g_or;

    initial begin
        rst_n = 1'b0; a = 1'b0; req = 4'd0; cfg_valid = 1'b0; cfg_div = 4'd0;
        @(negedge clk);
        #1;
        do_reset();
        chk("rst_grant",     {28'd0, grant},     32'd0);
        chk("rst_drop",      {31'd0, drop},      32'd0);
        chk("rst_drop_cnt",  {24'd0, drop_cnt},  32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk_en = 1'b1;

        // Ratio 2, all requesting: rotating grant every second token
        tick(1'b0, 4'hF, 1'b1, 4'd2);
        tab = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 4'hF, 1'b0, 4'd0);
            chk("div2_seq", {28'd0, grant}, {28'd0, tab[i]});
        end

        // Halving with gaps in the token stream
        do_reset();
        tick(1'b0, 4'hF, 1'b1, 4'd2);
        tab = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h4};
        for (int i = 0; i < 8; i++) begin
            tick((i != 2) && (i != 4), 4'hF, 1'b0, 4'd0);
            chk("halving", {28'd0, grant}, {28'd0, tab[i]});
        end

        // Ratio 3 with nobody requesting: two drops, no grants
        do_reset();
        tick(1'b0, 4'h0, 1'b1, 4'd3);
        n_drop = 0; g_or = 4'd0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 4'h0, 1'b0, 4'd0);
            n_drop += int'(drop);
            g_or |= grant;
        end
        chk("div3_drops",    n_drop,            32'd2);
        chk("div3_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        chk("div3_nogrant",  {28'd0, g_or},     32'd0);

        // Zero ratio loads as one; alternating sparse requesters
        do_reset();
        tick(1'b0, 4'h5, 1'b1, 4'd0);
        tab = '{4'h1, 4'h4, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'h5, 1'b0, 4'd0);
            chk("div0_seq", {28'd0, grant}, {28'd0, tab[i]});
        end

        // Deferred ratio change: 4 -> 2 offered at count 1
        do_reset();
        tick(1'b0, 4'hF, 1'b1, 4'd4);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        tick(1'b1, 4'hF, 1'b1, 4'd2);
        chk("pend_ready", {31'd0, cfg_ready}, 32'd0);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        chk("pend_t3", {28'd0, grant}, 32'd0);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        chk("pend_t4", {28'd0, grant}, 32'd1);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        chk("pend_t5",    {28'd0, grant},     32'd0);
        chk("pend_exit",  {31'd0, cfg_ready}, 32'd1);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        chk("pend_t6", {28'd0, grant}, 32'd2);

        // Saturating drop counter on the narrow instance
        do_reset();
        tick(1'b0, 4'h0, 1'b1, 4'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 4'h0, 1'b0, 4'd0);
        chk("sat_drop_cnt2", {30'd0, drop_cnt2}, 32'd3);
        chk("sat_drop_cnt",  {24'd0, drop_cnt},  32'd5);

        // Reset while pending with a token being selected
        do_reset();
        tick(1'b0, 4'hF, 1'b1, 4'd4);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        tick(1'b1, 4'hF, 1'b1, 4'd2);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        a = 1'b1; req = 4'hF; cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rstpend_grant", {28'd0, grant},     32'd0);
        chk("rstpend_drop",  {31'd0, drop},      32'd0);
        chk("rstpend_ready", {31'd0, cfg_ready}, 32'd1);
        tick(1'b1, 4'hF, 1'b0, 4'd0);
        chk("rstpend_idle", {28'd0, grant}, 32'd0);

        // Randomised traffic, config changes and occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                     $urandom_range(0, 9) == 0,
                     4'($urandom_range(0, 5)));
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_token_scheduler
`default_nettype wire

// File: doc/token_scheduler.md
TOKEN_SCHEDULER -- requirements
Module: token_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of token requesters (2..8).
REQ-002 Parameter CNT_W, default 4, width of divide ratio and token counter.
REQ-003 Parameter DROP_W, default 8, width of saturating drop counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  1  serial token stream, one token per cycle when high
- req  input  N_REQ  per-requester token request, level
- cfg_valid  input  1  new divide ratio offered
- cfg_div  input  CNT_W  divide ratio N: pass 1 of every N tokens
- cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
- grant  output  N_REQ  one-hot, one-cycle pulse: token delivered
- drop  output  1  one-cycle pulse: selected token had no requester
- drop_cnt  output  DROP_W  saturating count of drop pulses

Function
REQ-005 FSM states SHALL be IDLE, RUN and PEND; cfg_ready SHALL be 1 in IDLE and RUN, 0 in PEND.
REQ-006 IDLE: tokens ignored, no grant/drop; cfg handshake loads div, clears cnt, moves to RUN.
REQ-007 cfg_div = 0 SHALL be loaded as 1 (every token selected).
REQ-008 RUN: each cycle with a=1 increments cnt; the token is selected when cnt == div-1, and cnt wraps to 0 that cycle.
REQ-009 Cycles with a=0 SHALL leave cnt unchanged; non-selected tokens produce no output.
REQ-010 A selected token SHALL go to the first asserted req bit in round-robin order starting at last_grant+1 (mod N_REQ).
REQ-011 grant SHALL be registered: pulse appears exactly one cycle after the selecting a=1 cycle; last_grant updates with it.
REQ-012 A selected token with req == 0 SHALL pulse drop one cycle later, leave last_grant unchanged, and increment drop_cnt, saturating at all-ones.
REQ-013 grant and drop SHALL be mutually exclusive; at most one grant bit set.
REQ-014 RUN with cfg handshake: if cnt == 0 and a=0, new div applies next cycle, stay RUN; otherwise capture div into pending register, go PEND.
REQ-015 PEND: current div stays in force; on the first cycle cnt == 0 (after a wrap or already 0 with a=0) pending div becomes active, state returns to RUN.
REQ-016 A token arriving in the same cycle PEND exits SHALL be counted against the new div.
REQ-017 With div=2 and all req high, a = 1101_0111 (first bit first) SHALL yield grants after the 2nd, 4th and 6th tokens (halving).

Reset
REQ-018 rst_n low SHALL asynchronously force: state IDLE, cnt 0, div 1, pending 1, last_grant N_REQ-1, grant 0, drop 0, drop_cnt 0.
REQ-019 cfg_ready SHALL be 1 during and after reset (IDLE).
REQ-020 Reset asserted mid-operation SHALL discard pending config and any in-flight grant/drop pulse.

Structure
REQ-021 Package token_sched_pkg SHALL hold the state enum and default parameter constants.
REQ-022 Round-robin selection SHALL be a sub-module rr_arbiter (req, last_grant in; one-hot grant, any out), purely combinational.
REQ-023 All state SHALL sit in token_scheduler; no latches, no combinational path from a to grant.

Verification
REQ-024 Reset, cfg_div=2, req=4'b1111, a=1 for 8 cycles -> grant 0001,0010,0100,1000 on cycles 3,5,7,9 after load.
REQ-025 cfg_div=3, req=0, 6 tokens -> 2 drop pulses, drop_cnt=2, no grant.
REQ-026 cfg_div=0, req=4'b0101, 4 consecutive tokens -> grant 0001,0100,0001,0100 on consecutive cycles.
REQ-027 div=4, cnt=1, cfg_div=2 offered -> state PEND, cfg_ready=0; tokens 3 and 4 under old div, then grants every 2nd token.
REQ-028 DROP_W=2, 5 unserved selected tokens -> drop_cnt saturates at 3.
REQ-029 rst_n pulsed low while in PEND with token selected -> next cycle grant=0, drop=0, state IDLE, cfg_ready=1.
